// File: rtl/load_store_module.sv
// Word-addressed load/store unit: private single-port RAM and a four-state FSM.
// The FSM allows only one memory access per request, even while an enable stays high.
module load_store_module #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_en,
    input  logic                  st_en,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic                  is_store_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] read_data_r;
    logic                  req_s;

    // The RAM is zero at configuration. Reset does not touch it.
    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1] = '{default: '0};

    // Upper address bits are ignored, so addresses wrap modulo DEPTH.
    logic unused_addr_s;
    assign unused_addr_s = ^addr[31:ADDR_WIDTH];

    assign req_s = ld_en | st_en;

    // Next-state logic of the request/response FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS:  state_nxt_s = ST_RESP;
            ST_RESP:    state_nxt_s = ST_RELEASE;
            ST_RELEASE: begin
                if (req_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // State register, request capture, load result and ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            is_store_r  <= 1'b0;
            ready_r     <= 1'b0;
            read_data_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_r == ST_ACCESS);
            if (state_r == ST_IDLE && req_s) begin
                addr_r     <= addr[ADDR_WIDTH-1:0];
                wdata_r    <= write_data;
                // A store wins when both enables are high.
                is_store_r <= st_en;
            end
            if (state_r == ST_ACCESS && !is_store_r) begin
                read_data_r <= mem_r[addr_r];
            end
        end
    end

    // Memory write port. Reset in the ACCESS cycle cancels the write.
    always_ff @(posedge clk) begin
        if (!reset && state_r == ST_ACCESS && is_store_r) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign read_data = read_data_r;
    assign ready     = ready_r;

endmodule

// File: tb/tb_load_store_module.sv
// Directed bench for load_store_module: core-style handshakes with hand-computed
// expected values, covering reset, wrap, held enable, dual enables and mid-op reset.
module tb_load_store_module;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_en;
    logic        st_en;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    int n_checks = 0;
    int n_errors = 0;

    load_store_module #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_en      (ld_en),
        .st_en      (st_en),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count cycles until ready is seen, giving up after 10 cycles (returns 99).
    task automatic wait_ready(output int cnt);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (ready) return;
        end
        cnt = 99;
    endtask

    // Count ready pulses seen over n cycles.
    task automatic count_ready(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready) pulses++;
        end
    endtask

    // Core-style request: raise enables, wait for ready, drop enables.
    task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input string tag, output logic [31:0] rd);
        int cnt;
        int pulses;
        ld_en = ld; st_en = st; addr = a; write_data = d;
        wait_ready(cnt);
        check({tag, "_latency"}, cnt, 32'd2);
        rd = read_data;
        ld_en = 1'b0; st_en = 1'b0;
        addr = 32'hFFFF_FFFF; write_data = 32'h0BAD_0BAD;
        count_ready(4, pulses);
        check({tag, "_extra_ready"}, pulses, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int cnt;
        int pulses;

        reset = 1'b1; ld_en = 1'b1; st_en = 1'b0; addr = 32'd0; write_data = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("reset_ready", {31'd0, ready}, 32'd0);
            check("reset_rdata", read_data, 32'd0);
        end
        reset = 1'b0; ld_en = 1'b0;
        count_ready(3, pulses);
        check("post_reset_ready", pulses, 32'd0);

        do_req(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, "st5", rd);
        do_req(1'b1, 1'b0, 32'd5, 32'd0, "ld5", rd);
        check("ld5_data", rd, 32'hDEAD_BEEF);

        do_req(1'b0, 1'b1, 32'h0000_0401, 32'h1234_5678, "st401", rd);
        do_req(1'b1, 1'b0, 32'd1, 32'd0, "ld1", rd);
        check("wrap_data", rd, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'd7, 32'd0, "ld7", rd);
        check("unwritten_data", rd, 32'h0000_0000);

        // Held enable: one access, then silence until the enable drops and returns.
        ld_en = 1'b1; addr = 32'd5;
        wait_ready(cnt);
        check("held_latency", cnt, 32'd2);
        check("held_data", read_data, 32'hDEAD_BEEF);
        count_ready(10, pulses);
        check("held_no_second", pulses, 32'd0);
        ld_en = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 32'd1, 32'd0, "rehold", rd);
        check("rehold_data", rd, 32'h1234_5678);

        do_req(1'b1, 1'b1, 32'd3, 32'hA5A5_A5A5, "both", rd);
        check("both_rdata_kept", rd, 32'h1234_5678);
        do_req(1'b1, 1'b0, 32'd3, 32'd0, "ld3", rd);
        check("both_mem", rd, 32'hA5A5_A5A5);

        // Reset during ACCESS: store dropped, no ready, read_data cleared.
        st_en = 1'b1; addr = 32'd9; write_data = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        reset = 1'b1; st_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_rdata", read_data, 32'd0);
        count_ready(5, pulses);
        check("midreset_no_ready", pulses, 32'd0);
        do_req(1'b1, 1'b0, 32'd9, 32'd0, "ld9", rd);
        check("midreset_mem", rd, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
